// File: rtl/exu_oitf_pkg.sv
// rtl/exu_oitf_pkg.sv - shared sizes and hazard helper for the outstanding instruction track FIFO
package exu_oitf_pkg;

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = $clog2(E203_OITF_DEPTH);
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;

  // One entry's contribution to a hazard: live entry that writes rd, operand in use,
  // same register index and same register file (integer vs FPU).
  function automatic logic oitf_hit(
    input logic valid,
    input logic rdwen,
    input logic opnd_en,
    input logic idx_eq,
    input logic fpu_eq
  );
    return valid & rdwen & opnd_en & idx_eq & fpu_eq;
  endfunction

endpackage

// File: rtl/oitf_wrap_ptr.sv
// rtl/oitf_wrap_ptr.sv - circular index counter with a wrap flag for full/empty disambiguation
module oitf_wrap_ptr #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena_i,
  output logic [W-1:0] idx_o,
  output logic         flag_o
);

  logic [W-1:0] idx_q, idx_d;
  logic         flag_q, flag_d;

  // Advance by one; stepping past the last slot returns to 0 and flips the lap flag.
  always_comb begin
    idx_d  = idx_q;
    flag_d = flag_q;
    if (ena_i) begin
      if (idx_q == W'(DEPTH - 1)) begin
        idx_d  = '0;
        flag_d = ~flag_q;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      flag_q <= flag_d;
    end
  end

  assign idx_o  = idx_q;
  assign flag_o = flag_q;

endmodule

// File: rtl/exu_oitf.sv
// rtl/exu_oitf.sv - outstanding instruction track FIFO with RAW/WAW hazard detection
module exu_oitf
  import exu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH  = E203_OITF_DEPTH,
  parameter int ITAG_WIDTH  = $clog2(OITF_DEPTH),
  parameter int RFIDX_WIDTH = E203_RFIDX_WIDTH,
  parameter int PC_SIZE     = E203_PC_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rs3en,
  input  logic                   disp_i_rs1fpu,
  input  logic                   disp_i_rs2fpu,
  input  logic                   disp_i_rs3fpu,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs3idx,
  input  logic                   disp_i_rdwen,
  input  logic                   disp_i_rdfpu,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [PC_SIZE-1:0]     disp_i_pc,
  input  logic                   ret_ena,
  output logic [ITAG_WIDTH-1:0]  ret_ptr,
  output logic                   ret_rdwen,
  output logic                   ret_rdfpu,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic [PC_SIZE-1:0]     ret_pc,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprs3,
  output logic                   oitfrd_match_disprd,
  output logic                   oitf_empty
);

  logic [ITAG_WIDTH-1:0] alc_idx, ret_idx;
  logic                  alc_flag, ret_flag;
  logic                  full, empty, alc_fire, ret_fire;

  logic [OITF_DEPTH-1:0]                  valid_v, rdwen_v, rdfpu_v;
  logic [OITF_DEPTH-1:0][RFIDX_WIDTH-1:0] rdidx_v;
  logic [OITF_DEPTH-1:0][PC_SIZE-1:0]     pc_v;
  logic [OITF_DEPTH-1:0]                  hit_rs1, hit_rs2, hit_rs3, hit_rd;

  // Illegal requests are masked here using pre-edge occupancy, so a retire never
  // opens room for an allocation within the same edge.
  assign empty    = (alc_idx == ret_idx) & (alc_flag == ret_flag);
  assign full     = (alc_idx == ret_idx) & (alc_flag != ret_flag);
  assign alc_fire = dis_ena & ~full;
  assign ret_fire = ret_ena & ~empty;

  oitf_wrap_ptr #(.DEPTH(OITF_DEPTH), .W(ITAG_WIDTH)) u_alc_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena_i  (alc_fire),
    .idx_o  (alc_idx),
    .flag_o (alc_flag)
  );

  oitf_wrap_ptr #(.DEPTH(OITF_DEPTH), .W(ITAG_WIDTH)) u_ret_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena_i  (ret_fire),
    .idx_o  (ret_idx),
    .flag_o (ret_flag)
  );

  for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_ent
    logic                   set_w, clr_w;
    logic                   valid_q, valid_d;
    logic                   rdwen_q, rdfpu_q;
    logic [RFIDX_WIDTH-1:0] rdidx_q;
    logic [PC_SIZE-1:0]     pc_q;

    assign set_w = alc_fire & (alc_idx == ITAG_WIDTH'(i));
    assign clr_w = ret_fire & (ret_idx == ITAG_WIDTH'(i));

    // Valid next state: allocation wins over retirement of the same slot.
    always_comb begin
      valid_d = valid_q;
      if (clr_w) valid_d = 1'b0;
      if (set_w) valid_d = 1'b1;
    end

    // Valid bit register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= valid_d;
    end

    // Payload capture on allocation; contents are meaningless while the slot is invalid.
    always_ff @(posedge clk) begin
      if (set_w) begin
        rdwen_q <= disp_i_rdwen;
        rdfpu_q <= disp_i_rdfpu;
        rdidx_q <= disp_i_rdidx;
        pc_q    <= disp_i_pc;
      end
    end

    assign valid_v[i] = valid_q;
    assign rdwen_v[i] = rdwen_q;
    assign rdfpu_v[i] = rdfpu_q;
    assign rdidx_v[i] = rdidx_q;
    assign pc_v[i]    = pc_q;
  end

  // Compare every live entry's rd against each dispatch operand.
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    hit_rs3 = '0;
    hit_rd  = '0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      hit_rs1[i] = oitf_hit(valid_v[i], rdwen_v[i], disp_i_rs1en,
                            rdidx_v[i] == disp_i_rs1idx, rdfpu_v[i] == disp_i_rs1fpu);
      hit_rs2[i] = oitf_hit(valid_v[i], rdwen_v[i], disp_i_rs2en,
                            rdidx_v[i] == disp_i_rs2idx, rdfpu_v[i] == disp_i_rs2fpu);
      hit_rs3[i] = oitf_hit(valid_v[i], rdwen_v[i], disp_i_rs3en,
                            rdidx_v[i] == disp_i_rs3idx, rdfpu_v[i] == disp_i_rs3fpu);
      hit_rd[i]  = oitf_hit(valid_v[i], rdwen_v[i], disp_i_rdwen,
                            rdidx_v[i] == disp_i_rdidx, rdfpu_v[i] == disp_i_rdfpu);
    end
  end

  assign oitfrd_match_disprs1 = |hit_rs1;
  assign oitfrd_match_disprs2 = |hit_rs2;
  assign oitfrd_match_disprs3 = |hit_rs3;
  assign oitfrd_match_disprd  = |hit_rd;

  assign dis_ready  = ~full;
  assign dis_ptr    = alc_idx;
  assign oitf_empty = empty;
  assign ret_ptr    = ret_idx;
  assign ret_rdwen  = rdwen_v[ret_idx];
  assign ret_rdfpu  = rdfpu_v[ret_idx];
  assign ret_rdidx  = rdidx_v[ret_idx];
  assign ret_pc     = pc_v[ret_idx];

  // Dropped handshakes indicate an upstream protocol slip.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(dis_ena && full))
    else $warning("exu_oitf: dis_ena while full was ignored");
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(ret_ena && empty))
    else $warning("exu_oitf: ret_ena while empty was ignored");

endmodule
